// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use and branch-operand
// hazard detection, mult/div busy sequencing and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic             D_usesRs,
    input  logic             D_usesRt,
    input  logic             D_isBranch,
    input  logic             D_branchTaken,
    input  logic             D_isMulDiv,
    input  logic             D_readsHiLo,
    input  logic             E_memRead,
    input  logic             E_regWrite,
    input  logic [4:0]       E_writeReg,
    input  logic             M_memRead,
    input  logic [4:0]       M_writeReg,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] BUSY_LOAD = 8'(MD_LATENCY - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic e_match, m_match;
    logic lu_haz, br_haz, md_haz, stall;
    logic issue;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign e_match = (E_writeReg != 5'd0) &&
                     (((E_writeReg == D_rs) && D_usesRs) ||
                      ((E_writeReg == D_rt) && D_usesRt));
    assign m_match = (M_writeReg != 5'd0) &&
                     (((M_writeReg == D_rs) && D_usesRs) ||
                      ((M_writeReg == D_rt) && D_usesRt));

    assign lu_haz = E_memRead && e_match;
    assign br_haz = D_isBranch && ((E_regWrite && e_match) || (M_memRead && m_match));
    assign md_haz = (state == MD_BUSY) && (D_isMulDiv || D_readsHiLo);
    assign stall  = lu_haz || br_haz || md_haz;
    assign issue  = D_isMulDiv && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (issue) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = BUSY_LOAD;
                end
            end
            MD_BUSY: begin
                // Final busy cycle is cnt==0; the following cycle is RUN.
                if (cnt == 8'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        if (!rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            md_busy  = (state == MD_BUSY);
            md_start = issue;
            if (stall) begin
                // An unresolved branch must not flush, so stall wins.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else begin
                ifid_flush = D_isBranch && D_branchTaken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk, rst;
    logic [4:0]       D_rs, D_rt;
    logic             D_usesRs, D_usesRt, D_isBranch, D_branchTaken;
    logic             D_isMulDiv, D_readsHiLo;
    logic             E_memRead, E_regWrite;
    logic [4:0]       E_writeReg;
    logic             M_memRead;
    logic [4:0]       M_writeReg;
    logic             pc_en, ifid_en, ifid_flush, idex_flush, md_start, md_busy;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .D_rs(D_rs), .D_rt(D_rt), .D_usesRs(D_usesRs), .D_usesRt(D_usesRt),
        .D_isBranch(D_isBranch), .D_branchTaken(D_branchTaken),
        .D_isMulDiv(D_isMulDiv), .D_readsHiLo(D_readsHiLo),
        .E_memRead(E_memRead), .E_regWrite(E_regWrite), .E_writeReg(E_writeReg),
        .M_memRead(M_memRead), .M_writeReg(M_writeReg),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .md_start(md_start), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index, cycle of the last mult/div issue, stall tally.
    int cyc = 0;
    int last_issue = -1000;
    int scnt = 0;

    function automatic logic f_match(input logic [4:0] r);
        return (r != 0) && ((r == D_rs && D_usesRs) || (r == D_rt && D_usesRt));
    endfunction

    function automatic logic m_busy();
        return (cyc > last_issue) && (cyc <= last_issue + LAT);
    endfunction

    function automatic logic m_stall();
        logic lu, br, md;
        lu = E_memRead && f_match(E_writeReg);
        br = D_isBranch && ((E_regWrite && f_match(E_writeReg)) || (M_memRead && f_match(M_writeReg)));
        md = m_busy() && (D_isMulDiv || D_readsHiLo);
        return lu || br || md;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_issue <= -1000;
            scnt       <= 0;
        end else begin
            if (m_stall()) scnt <= (scnt >= SAT) ? SAT : scnt + 1;
            if (D_isMulDiv && !m_stall()) last_issue <= cyc;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_pc_en", pc_en, 0);
            check("rst_ifid_en", ifid_en, 0);
            check("rst_ifid_flush", ifid_flush, 1);
            check("rst_idex_flush", idex_flush, 1);
            check("rst_md_start", md_start, 0);
            check("rst_md_busy", md_busy, 0);
            check("rst_stall_cycles", stall_cycles, 0);
        end else begin
            check("pc_en", pc_en, !m_stall());
            check("ifid_en", ifid_en, !m_stall());
            check("idex_flush", idex_flush, m_stall());
            check("ifid_flush", ifid_flush, !m_stall() && D_isBranch && D_branchTaken);
            check("md_start", md_start, D_isMulDiv && !m_stall());
            check("md_busy", md_busy, m_busy());
            check("stall_cycles", stall_cycles, scnt);
        end
    end

    task automatic idle();
        D_rs = 0; D_rt = 0; D_usesRs = 0; D_usesRt = 0;
        D_isBranch = 0; D_branchTaken = 0; D_isMulDiv = 0; D_readsHiLo = 0;
        E_memRead = 0; E_regWrite = 0; E_writeReg = 0;
        M_memRead = 0; M_writeReg = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, second;
        idle();
        rst = 1'b0;
        #12;
        check("lit_reset_pc_en", pc_en, 0);
        check("lit_reset_ifid_flush", ifid_flush, 1);
        rst = 1'b1;
        next();
        next();

        // load-use on rs
        E_memRead = 1; E_writeReg = 5; D_rs = 5; D_usesRs = 1;
        @(negedge clk);
        check("lit_lu_pc_en", pc_en, 0);
        check("lit_lu_idex_flush", idex_flush, 1);
        next();
        idle();
        @(negedge clk);
        check("lit_lu_released", pc_en, 1);
        check("lit_lu_count", stall_cycles, 1);
        next();
        E_memRead = 1; E_writeReg = 0; D_rs = 0; D_usesRs = 1;
        @(negedge clk);
        check("lit_r0_no_stall", pc_en, 1);
        next();

        // branch operand hazards: EX writer then MEM load
        idle();
        D_isBranch = 1; D_rt = 9; D_usesRt = 1; D_branchTaken = 1;
        E_regWrite = 1; E_writeReg = 9;
        @(negedge clk);
        check("lit_br_ex_stall", ifid_en, 0);
        check("lit_br_ex_noflush", ifid_flush, 0);
        next();
        E_regWrite = 0; E_writeReg = 0; M_memRead = 1; M_writeReg = 9;
        @(negedge clk);
        check("lit_br_mem_stall", pc_en, 0);
        next();
        M_memRead = 0; M_writeReg = 0;
        @(negedge clk);
        check("lit_br_taken_flush", ifid_flush, 1);
        check("lit_br_count", stall_cycles, 3);
        next();

        // mult/div issue then mfhi waits out the busy window
        idle();
        D_isMulDiv = 1;
        @(negedge clk);
        check("lit_md_start", md_start, 1);
        next();
        idle();
        D_readsHiLo = 1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("lit_md_busy", md_busy, 1);
            check("lit_mfhi_stall", pc_en, 0);
            next();
        end
        @(negedge clk);
        check("lit_mfhi_go", pc_en, 1);
        check("lit_md_idle", md_busy, 0);
        next();

        // back-to-back mult/div
        idle();
        D_isMulDiv = 1;
        first = -1; second = -1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            @(negedge clk);
            if (md_start) begin
                if (first < 0) first = i;
                else second = i;
            end
            next();
        end
        check("b2b_gap", second - first, LAT + 1);
        idle();

        // async reset during a busy window
        for (int i = 0; i < 40 && !(md_busy === 1'b0); i++) next();
        D_isMulDiv = 1;
        next();
        D_isMulDiv = 0;
        next();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("lit_arst_md_busy", md_busy, 0);
        check("lit_arst_idex_flush", idex_flush, 1);
        check("lit_arst_count", stall_cycles, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        next();
        D_readsHiLo = 1;
        @(negedge clk);
        check("lit_post_rst_mfhi", pc_en, 1);
        next();

        // saturation
        idle();
        E_memRead = 1; E_writeReg = 7; D_rt = 7; D_usesRt = 1;
        for (int i = 0; i < 20; i++) next();
        @(negedge clk);
        check("lit_saturate", stall_cycles, SAT);
        next();
        idle();

        // randomized traffic on a small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            next();
            D_rs          = 5'($urandom_range(0, 3));
            D_rt          = 5'($urandom_range(0, 3));
            D_usesRs      = 1'($urandom);
            D_usesRt      = 1'($urandom);
            D_isBranch    = ($urandom_range(0, 3) == 0);
            D_branchTaken = 1'($urandom);
            D_isMulDiv    = ($urandom_range(0, 5) == 0);
            D_readsHiLo   = ($urandom_range(0, 4) == 0);
            E_memRead     = ($urandom_range(0, 3) == 0);
            E_regWrite    = 1'($urandom);
            E_writeReg    = 5'($urandom_range(0, 3));
            M_memRead     = ($urandom_range(0, 3) == 0);
            M_writeReg    = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                #3 rst = 1'b0;
                #3 rst = 1'b1;
            end
        end
        next();
        idle();
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards.
- Sequences the multi-cycle multiply/divide unit with a busy countdown FSM.
- Drives PC enable, IF/ID enable and flush, and ID/EX flush.
- All outputs are combinational from registered state plus current stage inputs, so they are stable before the negedge at which IF/ID samples.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue (legal 2..255).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- D_rs, D_rt  in  5 each  source register numbers of the instruction in ID.
- D_usesRs, D_usesRt  in  1 each  ID instruction actually reads rs / rt.
- D_isBranch  in  1  ID instruction is a branch compared in ID.
- D_branchTaken  in  1  branch resolved taken in ID; valid only when D_isBranch=1.
- D_isMulDiv  in  1  ID instruction is mult/multu/div/divu.
- D_readsHiLo  in  1  ID instruction is mfhi/mflo.
- E_memRead, E_regWrite  in  1 each  EX-stage instruction is a load / writes a register.
- E_writeReg  in  5  destination register of the EX-stage instruction.
- M_memRead  in  1  MEM-stage instruction is a load.
- M_writeReg  in  5  destination register of the MEM-stage instruction.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register flush.
- idex_flush  out  1  insert a bubble into ID/EX.
- md_start  out  1  one-cycle issue pulse to the mult/div unit.
- md_busy  out  1  high while state = MD_BUSY.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- match(r) = (r != 0) && ((r == D_rs && D_usesRs) || (r == D_rt && D_usesRt)). Register 0 never causes a hazard.
- lu_haz = E_memRead && match(E_writeReg).
- br_haz = D_isBranch && ((E_regWrite && match(E_writeReg)) || (M_memRead && match(M_writeReg))).
- md_haz = (state == MD_BUSY) && (D_isMulDiv || D_readsHiLo).
- stall = lu_haz | br_haz | md_haz.
- When stall=1: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
- When stall=0: pc_en=1, ifid_en=1, idex_flush=0, ifid_flush = D_isBranch && D_branchTaken.
- Stall has priority over flush: an unresolved branch never flushes.
- md_start = D_isMulDiv && !stall. In state RUN it is a single cycle per issue, because the instruction leaves ID.
- FSM, two states:
  - RUN -> MD_BUSY on posedge when md_start=1; cnt <= MD_LATENCY-1.
  - MD_BUSY: cnt decrements every posedge. When cnt==0, next state is RUN.
  - md_haz holds through the final busy cycle (cnt==0). A waiting mfhi/mflo or mult/div proceeds on the first RUN cycle.
  - A mult/div waiting in ID issues on that first RUN cycle, giving back-to-back busy windows with exactly one RUN cycle between them.
- stall_cycles increments on each posedge where stall=1 and saturates at all-ones; it never wraps.
- Simultaneous hazards produce the same outputs as any single hazard, and stall_cycles counts the cycle once.
- While rst=0 (asynchronous, takes effect immediately, including mid-MD_BUSY):
  - state=RUN, cnt=0, stall_cycles=0.
  - Outputs forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, md_start=0, md_busy=0.
  - After release, normal decode resumes at the next cycle with no residual busy window.
- No X propagation: all outputs are fully decoded in every state. Any illegal state recovers to RUN.

Test Plan:
- Load-use: E_memRead=1, E_writeReg=5, D_rs=5, D_usesRs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cycles=1. Repeat with E_writeReg=0 -> no stall.
- Branch operand: D_isBranch=1, D_rt=9, D_usesRt=1; E_regWrite=1, E_writeReg=9 one cycle, then M_memRead=1, M_writeReg=9 the next -> 2 stall cycles with ifid_flush=0. Then D_branchTaken=1 with no hazard -> ifid_flush=1 for 1 cycle.
- Mult/div with MD_LATENCY=4: D_isMulDiv=1 one cycle -> md_start pulse; md_busy high 4 cycles. mfhi in ID the cycle after issue -> stalled 4 cycles, advances on cycle 5.
- Back-to-back mult/div (D_isMulDiv held) -> second md_start exactly 5 cycles after the first; no overlapping busy window.
- Reset mid-operation: assert rst=0 at busy cycle 2, asynchronously between edges -> md_busy=0, idex_flush=1 immediately; after release, mfhi in ID is not stalled; stall_cycles=0.
- Saturation with CNT_W=4: hold lu_haz for 20 cycles -> stall_cycles reaches 15 and stays at 15.
